// File: rtl/stdp_pkg.sv
// Shared constants for the synaptic stage between the STDP learner and
// the postsynaptic LIF neuron.
//   WIDTH_DEF    : default bit width of the weight and the synaptic current
//   W_INIT_DEF   : weight register value after reset
//   CURRENT_MAX  : saturation ceiling for the default width
//   DELAY_*      : legal axonal delay range, in enabled cycles
//   SHIFT_*      : legal leak shift range
package stdp_pkg;

   localparam int WIDTH_DEF   = 8;
   localparam int W_INIT_DEF  = 1;
   localparam int CURRENT_MAX = (1 << WIDTH_DEF) - 1;

   localparam int DELAY_MIN   = 1;
   localparam int DELAY_MAX   = 15;
   localparam int SHIFT_MIN   = 1;
   localparam int SHIFT_MAX   = 7;

endpackage

// File: rtl/spike_delay_line.sv
// Axonal delay: a DELAY-stage shift register for the presynaptic spike.
// The spike sampled at edge k appears on dout after edge k+DELAY-1.
// Back-to-back spikes occupy separate stages, so they are never merged.
//   clk  : clock
//   rst  : synchronous active-high reset; clears every stage
//   en   : clock enable; low freezes the whole line
//   din  : spike input
//   dout : delayed spike (registered; this is the last stage)
module spike_delay_line
   import stdp_pkg::*;
#(
   parameter int DELAY = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic dout
);

   generate
      if (DELAY < DELAY_MIN || DELAY > DELAY_MAX) begin : g_bad_delay
         $error("spike_delay_line: DELAY out of range");
      end
   endgenerate

   logic [DELAY-1:0] r_stages;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stages <= '0;
      end else if (en) begin
         r_stages[0] <= din;
         for (int i = 1; i < DELAY; i++) begin
            r_stages[i] <= r_stages[i-1];
         end
      end
   end

   assign dout = r_stages[DELAY-1];

endmodule

// File: rtl/synapse_current.sv
// Synaptic stage: delays the presynaptic spike, then injects the learned
// weight into a leaky, saturating synaptic-current register that feeds the
// postsynaptic LIF neuron.
//   clk           : clock
//   rst           : synchronous active-high reset (wins over en)
//   en            : clock enable; low freezes all state, ignores inputs
//   pre_spike     : presynaptic spike, one cycle per spike
//   weight        : new weight from the STDP block
//   weight_valid  : loads weight into the weight register
//   spike_delayed : pre_spike delayed by DELAY enabled cycles
//   current       : saturating synaptic current
//   sat           : high for the cycle after an update that clipped
module synapse_current
   import stdp_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int DELAY       = 3,
   parameter int DECAY_SHIFT = 2,
   parameter int W_INIT      = W_INIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pre_spike,
   input  logic [WIDTH-1:0] weight,
   input  logic             weight_valid,
   output logic             spike_delayed,
   output logic [WIDTH-1:0] current,
   output logic             sat
);

   generate
      if (DECAY_SHIFT < SHIFT_MIN || DECAY_SHIFT > SHIFT_MAX) begin : g_bad_shift
         $error("synapse_current: DECAY_SHIFT out of range");
      end
   endgenerate

   localparam logic [WIDTH:0] L_MAX = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] r_current;
   logic [WIDTH-1:0] r_w;
   logic             r_sat;
   logic             w_spike_delayed;
   logic [WIDTH-1:0] w_leak;
   logic [WIDTH:0]   w_inj;
   logic [WIDTH:0]   w_sum;

   spike_delay_line #(
      .DELAY (DELAY)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .din  (pre_spike),
      .dout (w_spike_delayed)
   );

   // A small nonzero current would otherwise shift to a zero leak and
   // stick forever; forcing a leak of 1 guarantees it drains to 0.
   // The sum needs one extra bit: current - leak + weight can exceed the
   // ceiling but can never go negative since leak <= current.
   always_comb begin
      w_leak = r_current >> DECAY_SHIFT;
      if (r_current != '0 && w_leak == '0) begin
         w_leak = {{(WIDTH-1){1'b0}}, 1'b1};
      end
      w_inj = w_spike_delayed ? {1'b0, r_w} : '0;
      w_sum = {1'b0, r_current} - {1'b0, w_leak} + w_inj;
   end

   // The injection reads r_w before any same-edge weight load lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_current <= '0;
         r_w       <= WIDTH'(W_INIT);
         r_sat     <= 1'b0;
      end else if (en) begin
         if (weight_valid) begin
            r_w <= weight;
         end
         r_current <= (w_sum > L_MAX) ? L_MAX[WIDTH-1:0] : w_sum[WIDTH-1:0];
         r_sat     <= (w_sum > L_MAX);
      end
   end

   assign spike_delayed = w_spike_delayed;
   assign current       = r_current;
   assign sat           = r_sat;

endmodule
